// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields and a full-width immediate into a word,
// registered with a sequential byte address. INSTR_ENCODER_RANGE_CHECK_EN adds immediate checks.
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              accept, xfer;
  logic [31:0]       word;
  logic              illegal;
  logic              range_bad;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = valid_q && out_ready;

  always_comb begin
    word    = Nop;
    illegal = 1'b0;
    case (fmt)
      3'd0: word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: word = {imm[11:0], rs1, funct3, rd, opcode};
      3'd2: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      3'd3: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      3'd4: word = {imm[31:12], rd, opcode};
      3'd5: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: begin
        word    = Nop;
        illegal = 1'b1;
      end
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // Flags immediates whose high bits would be lost by the packing above.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      3'd1, 3'd2: range_bad = (imm != {{20{imm[11]}}, imm[11:0]});
      3'd3:       range_bad = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
      3'd4:       range_bad = (imm[11:0] != 12'd0);
      3'd5:       range_bad = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
      default:    range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    instr_d = instr_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (xfer) begin
      cnt_d   = cnt_q + ADDR_W'(4);
      valid_d = 1'b0;
    end
    // A word accepted alongside a transfer takes the already-advanced address.
    if (accept) begin
      valid_d = 1'b1;
      instr_d = word;
      addr_d  = cnt_d;
      err_d   = err_q | illegal | range_bad;
    end
    if (clear) begin
      cnt_d   = BASE_ADDR;
      valid_d = 1'b0;
      addr_d  = BASE_ADDR;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      addr_q  <= BASE_ADDR;
      cnt_q   <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus pushes expected words, a monitor pops on transfer.
module tb_instr_encoder;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn, clear, in_valid, in_ready, out_valid, out_ready, err;
  logic [2:0]  fmt, funct3;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, out_instr, out_addr;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_err;
  logic [31:0] w_out_instr;
  logic [3:0]  w_out_addr;

  int   checks = 0;
  int   passes = 0;
  exp_t q[$];
  int   k = 0;
  logic sticky = 1'b0;
  bit   rand_ready = 1'b0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .err(err)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut_wrap (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_addr(w_out_addr), .err(w_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] piece(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  function automatic logic [31:0] model_word(input logic [2:0] f, input logic [6:0] op,
      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] base;
    base = (32'(s1) << 15) | (32'(f3) << 12) | 32'(op);
    case (f)
      3'd0: return (32'(f7) << 25) | (32'(s2) << 20) | base | (32'(d) << 7);
      3'd1: return (piece(im, 11, 0) << 20) | base | (32'(d) << 7);
      3'd2: return (piece(im, 11, 5) << 25) | (32'(s2) << 20) | base | (piece(im, 4, 0) << 7);
      3'd3: return (piece(im, 12, 12) << 31) | (piece(im, 10, 5) << 25) | (32'(s2) << 20) | base
                   | (piece(im, 4, 1) << 8) | (piece(im, 11, 11) << 7);
      3'd4: return (im & 32'hFFFF_F000) | (32'(d) << 7) | 32'(op);
      3'd5: return (piece(im, 20, 20) << 31) | (piece(im, 10, 1) << 21) | (piece(im, 11, 11) << 20)
                   | (piece(im, 19, 12) << 12) | (32'(d) << 7) | 32'(op);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic model_range_bad(input logic [2:0] f, input logic [31:0] im);
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    int s;
    s = int'(im);
    case (f)
      3'd1, 3'd2: return !(s >= -2048 && s <= 2047);
      3'd3:       return !(s >= -4096 && s <= 4095 && (s % 2) == 0);
      3'd4:       return (im % 32'd4096) != 0;
      3'd5:       return !(s >= -1048576 && s <= 1048575 && (s % 2) == 0);
      default:    return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  task automatic push(input logic [31:0] w);
    exp_t e;
    sticky = sticky | (fmt > 3'd5) | model_range_bad(fmt, imm);
    e.w = w;
    e.a = 32'(k * 4);
    e.e = sticky;
    q.push_back(e);
    k++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
      input logic [31:0] im, input logic ovr, input logic [31:0] ow, output int waits);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        push(ovr ? ow : model_word(f, op, d, s1, s2, f3, f7, im));
        break;
      end
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 32'(waits), 32'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    logic [2:0]  f;
    logic [31:0] r, im;
    int          w;
    f = 3'($urandom_range(0, 7));
    r = $urandom;
    if ($urandom_range(0, 1) == 0) im = $urandom;
    else begin
      im = {{20{r[11]}}, r[11:0]};
      if (f == 3'd3 || f == 3'd5) im[0] = 1'b0;
      if (f == 3'd4) im = r & 32'hFFFF_F000;
    end
    send(f, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
         7'($urandom), im, 1'b0, 32'h0, w);
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (rstn && out_valid) check("in_ready_formula", 32'(in_ready), 32'(out_ready));
    if (rstn && out_valid && out_ready) begin
      if (q.size() == 0) check("sb_underflow", 32'(q.size()), 32'd1);
      else begin
        e = q.pop_front();
        check("sb_instr", out_instr, e.w);
        check("sb_addr", out_addr, e.a);
        check("sb_err", 32'(err), 32'(e.e));
      end
    end
  end

  initial begin
    int   w;
    int   n;
    logic exp_range_err;
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0;
    out_ready = 1'b1; w_out_ready = 1'b1;
    fmt = 3'd1; opcode = 7'h13; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_wrap_addr", 32'(w_out_addr), 32'd12);
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Address wrap on the 4-bit instance: 12 then 0.
    w_in_valid = 1'b1;
    tick();
    @(negedge clk);
    check("wrap_addr0", 32'(w_out_addr), 32'd12);
    tick();
    w_in_valid = 1'b0;
    @(negedge clk);
    check("wrap_valid1", 32'(w_out_valid), 32'd1);
    check("wrap_addr1", 32'(w_out_addr), 32'd0);
    check("wrap_err", 32'(w_err), 32'd0);
    tick();

    // Known encodings, back to back.
    send(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd273, 1'b1, 32'h1110_0013, w);
    check("b2b_stall0", 32'(w), 32'd0);
    send(3'd2, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd272, 1'b1, 32'h1000_0823, w);
    check("b2b_stall1", 32'(w), 32'd0);
    send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b1, 32'hFE00_0CE3, w);
    check("b2b_stall2", 32'(w), 32'd0);
    send(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_A000, 1'b1, 32'hFFFF_A037, w);
    check("b2b_stall3", 32'(w), 32'd0);
    send(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1, 32'h0020_006F, w);
    check("b2b_stall4", 32'(w), 32'd0);
    tick();
    tick();

    // Backpressure: hold a word for three cycles with the next one waiting.
    out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd6, 7'h20, 32'd0, 1'b0, 32'h0, w);
    fmt = 3'd1; opcode = 7'h13; rd = 5'd7; rs1 = 5'd8; funct3 = 3'd1; imm = 32'd100;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_instr", out_instr, q[0].w);
      check("bp_addr", out_addr, q[0].a);
      tick();
    end
    out_ready = 1'b1;
    send(3'd1, 7'h13, 5'd7, 5'd8, 5'd0, 3'd1, 7'd0, 32'd100, 1'b0, 32'h0, w);
    check("bp_release_stall", 32'(w), 32'd0);
    tick();

    // Immediate that overflows the I format.
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    exp_range_err = 1'b1;
`else
    exp_range_err = 1'b0;
`endif
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0, w);
    @(negedge clk);
    check("range_err", 32'(err), 32'(exp_range_err));
    check("range_imm_field", 32'(out_instr[31:20]), 32'h800);
    tick();

    // Illegal format, then clear with a simultaneous (dropped) input.
    send(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd2, 7'h1, 32'h1234, 1'b0, 32'h0, w);
    @(negedge clk);
    check("illegal_err", 32'(err), 32'd1);
    check("illegal_nop", out_instr, 32'h0000_0013);
    tick();
    tick();
    clear = 1'b1;
    in_valid = 1'b1;
    fmt = 3'd0;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    q.delete();
    k = 0;
    sticky = 1'b0;
    @(negedge clk);
    check("clear_valid", 32'(out_valid), 32'd0);
    check("clear_err", 32'(err), 32'd0);
    tick();
    send(3'd4, 7'h17, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0001_2000, 1'b0, 32'h0, w);
    tick();

    // Asynchronous reset while a word is held.
    out_ready = 1'b0;
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'h0, w);
    rstn = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_addr", out_addr, 32'd0);
    check("async_rst_instr", out_instr, 32'd0);
    q.delete();
    k = 0;
    sticky = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    out_ready = 1'b1;
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFF0, 1'b0, 32'h0, w);

    // Randomized traffic with random backpressure.
    rand_ready = 1'b1;
    repeat (300) send_rand();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check("sb_drain", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder: the inverse of the immediate generator. It accepts decoded instruction fields plus a full-width immediate over a valid/ready handshake, and packs them into a 32-bit instruction word. The word is registered and emitted with a sequential write address, so a test loader can fill instruction memory word by word.

## Interface
- `BASE_ADDR`, default 0: address tagged on the first emitted word after reset or `clear`.
- `ADDR_W`, default 32: width of `out_addr`.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rstn` in 1: reset, asynchronous and active-low.
- `clear` in 1: synchronous; reloads the address counter to `BASE_ADDR` and drops any held output.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder can accept this cycle.
- `fmt` in 3: format code. 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `opcode` in 7; `rd`, `rs1`, `rs2` in 5 each; `funct3` in 3; `funct7` in 7: instruction fields.
- `imm` in 32: immediate in the same form the immediate generator outputs it (sign-extended; U already shifted left by 12).
- `out_valid` out 1: `out_instr` and `out_addr` valid.
- `out_ready` in 1: downstream accepts.
- `out_instr` out 32: encoded instruction.
- `out_addr` out ADDR_W: byte address of `out_instr`.
- `err` out 1: sticky error flag.

## Operation
- Single output register stage. `in_ready = !out_valid || out_ready`, combinational, with no dependency on `in_valid`.
- Accept happens on `in_valid && in_ready`. The encoded word loads into `out_instr` and `out_valid` goes to 1. The current counter value loads into `out_addr`.
- Counter advances by 4 on each output transfer (`out_valid && out_ready`). It wraps modulo 2^ADDR_W.
- Packing; unused fields are ignored for each format:
  - R: `funct7 | rs2 | rs1 | funct3 | rd | opcode`.
  - I: `imm[11:0] | rs1 | funct3 | rd | opcode`.
  - S: `imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode`.
  - B: `imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode`.
  - U: `imm[31:12] | rd | opcode`.
  - J: `imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | opcode`.
- Illegal `fmt` (6, 7): emit `0x00000013` (nop) and set `err`. The word still consumes an address.
- `err` clears only on `rstn` low or `clear`.

## Timing
- Reset values: `out_valid`=0, `out_instr`=0, `out_addr`=BASE_ADDR, `err`=0. Internal counter = BASE_ADDR.
- Latency: 1 cycle from input accept to `out_valid`. Throughput is 1 word/cycle while `out_ready`=1.
- Backpressure: while `out_valid && !out_ready`, `out_instr` and `out_addr` hold stable and `in_ready`=0.
- Simultaneous output transfer and input accept: the new word replaces the old one with no bubble. Its `out_addr` is the old address + 4.
- `clear` has priority over an accept in the same cycle; the input is dropped (`in_ready` still reads per formula, the data is discarded). After `clear`, `out_valid`=0.
- Reset mid-transfer: the held word is discarded immediately (asynchronous). No partial state survives.
- Counter wrap at 2^ADDR_W−4 → 0 is silent. It does not set `err`.

## Configuration
- `INSTR_ENCODER_RANGE_CHECK_EN` defined: on accept, `err` is set when the immediate does not fit its format. The word is still emitted with truncated bits. The checks are:
  - I and S: `imm` must equal its 12-bit sign extension.
  - B: 13-bit sign extension, and `imm[0]`=0.
  - J: 21-bit sign extension, and `imm[0]`=0.
  - U: `imm[11:0]`=0.
- Undefined: no range logic. High bits are silently dropped, and `err` reflects only illegal `fmt`.

## Test plan
- Encode back-to-back with `out_ready`=1 and BASE_ADDR=0, one word per cycle. Required outputs at addresses 0, 4, 8, 12, 16:
  - addi (I, imm=273, opcode 0x13) → `0x11100013`.
  - sb (S, imm=272, opcode 0x23) → `0x10000823`.
  - beq (B, imm=-8, opcode 0x63) → `0xFE000CE3`.
  - lui (U, imm=0xFFFFA000, opcode 0x37) → `0xFFFFA037`.
  - jal (J, imm=2, opcode 0x6F) → `0x0020006F`.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1. Required: `in_ready`=0, and `out_instr`/`out_addr` are stable. Release → next word follows with no bubble and no drop.
- Range check, with the macro defined: I format with imm=2048 → `err`=1 and `out_instr[31:20]`=0x800. With the macro undefined, the same stimulus gives `err`=0.
- Illegal `fmt`=7 → `out_instr`=`0x00000013` and `err`=1. `clear` then gives `err`=0, `out_valid`=0, and the next word at BASE_ADDR.
- Reset mid-operation: assert `rstn`=0 while `out_valid`=1 and `out_ready`=0. Required: `out_valid`=0 with no clock edge needed, and after release the first word lands at BASE_ADDR.
- Wrap: ADDR_W=4, BASE_ADDR=12. Two transfers → addresses 12, then 0.
